fetch_queue: RTL and testbench

Instruction-fetch front end sitting directly upstream of the decode stage and its immediate generator. Issues pipelined requests to instruction memory, tracks in-flight requests, buffers returned instruction words with their PCs in an in-order queue, and presents them to decode through a valid/ready handshake. A branch/jump redirect flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entries carry the instruction word together with the PC it was fetched from.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: redirect input, instruction-memory request/response, decode handshake.
// master = fetch_queue side, slave = environment (memory, branch unit, decode).
interface fetch_queue_if;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input  imem_req, imem_addr, id_valid, id_instr, id_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetch entries with flush; push visible at head one cycle later, no bypass.
// Push into a full FIFO is a caller error; pop on empty is ignored; flush overrides push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  fetch_entry_t           push_dat,
   output fetch_entry_t           head_dat,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !flush;
      do_pop   = pop && !flush && (count_q != '0);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never reset; the head is zeroed while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count    = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(do_push && count_q == FULL));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: pipelined imem requests, in-order buffering, decode valid/ready; rvalid->id_valid 1 cycle.
// Requests stop when buffered+outstanding reaches DEPTH; redirect flushes and drops stale responses.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] ONE     = 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count;
   logic [CW-1:0] credit_used;
   logic          rsp_vld, accept, push, pop, req;
   fetch_entry_t  push_dat, head_dat;

   always_comb begin
      credit_used = count + inflight_q;
      // A response with nothing outstanding is a protocol error and is ignored.
      rsp_vld     = bus.imem_rvalid && (inflight_q != '0);
      req         = rst_n && !bus.redirect_valid && (credit_used < DEPTH_C);
      accept      = req && bus.imem_gnt;
      push        = rsp_vld && (discard_q == '0) && !bus.redirect_valid;
      pop         = (count != '0) && bus.id_ready && !bus.redirect_valid;
      push_dat.instr = bus.imem_rdata;
      push_dat.pc    = resp_pc_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      if (accept) begin
         fetch_pc_d = fetch_pc_q + INSTR_BYTES;
         inflight_d = inflight_d + ONE;
      end
      if (rsp_vld) inflight_d = inflight_d - ONE;
      if (bus.redirect_valid) begin
         // Everything still outstanding after this cycle belongs to the old stream.
         fetch_pc_d = align_pc(bus.redirect_pc);
         resp_pc_d  = align_pc(bus.redirect_pc);
         discard_d  = inflight_q - (rsp_vld ? ONE : '0);
      end else if (rsp_vld) begin
         if (discard_q != '0) discard_d = discard_q - ONE;
         else                 resp_pc_d = resp_pc_q + INSTR_BYTES;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.redirect_valid),
      .push     (push),
      .pop      (pop),
      .push_dat (push_dat),
      .head_dat (head_dat),
      .count    (count)
   );

   assign bus.imem_req  = req;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.id_valid  = (count != '0);
   assign bus.id_instr  = head_dat.instr;
   assign bus.id_pc     = head_dat.pc;

   a_rvalid_has_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      bus.imem_rvalid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with random latency, expected PC stream per redirect.
// A separate monitor pops the expected stream on every decode handshake.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   mreq_t pend[$];
   exp_t  sb[$];
   int cyc = 0;
   int last_due = 0;
   int gnt_mode, rdy_mode, lat_lo, lat_hi;
   int deliv = 0;
   logic [31:0] last_pc = '0;
   logic        s_req, s_idv;
   logic [31:0] s_addr, s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected decode stream after reset/redirect: consecutive words from the aligned target.
   task automatic sb_restart(input logic [31:0] target);
      logic [31:0] p;
      p = {target[31:2], 2'b00};
      sb.delete();
      for (int i = 0; i < 512; i++) begin
         sb.push_back('{pc: p, instr: mem_word(p)});
         p = p + 32'd4;
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1 &&
          bus.redirect_valid === 1'b0) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: unexpected pc %h", bus.id_pc);
         end else begin
            e = sb.pop_front();
            check("id_pc", bus.id_pc, e.pc);
            check("id_instr", bus.id_instr, e.instr);
         end
         deliv++;
         last_pc = bus.id_pc;
      end
   end

   // One clock cycle: drive at posedge+1, record at negedge, return at next posedge+1.
   task automatic step(input bit rd, input logic [31:0] rpc);
      int due;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_word(pend[0].addr);
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
      bus.imem_gnt       = (gnt_mode == 2) ? ($urandom_range(0, 1) == 1) : (gnt_mode == 1);
      bus.id_ready       = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;
      @(negedge clk);
      s_req  = bus.imem_req;
      s_addr = bus.imem_addr;
      s_idv  = bus.id_valid;
      s_pc   = bus.id_pc;
      if (bus.imem_rvalid) pend.delete(0);
      if (bus.imem_req && bus.imem_gnt) begin
         due = cyc + int'($urandom_range(lat_lo, lat_hi));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{addr: bus.imem_addr, due: due});
      end
      if (rd) sb_restart(rpc);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic wait_pc(input logic [31:0] target, input int budget, input string name);
      int d0;
      bit hit;
      d0  = deliv;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         step(1'b0, '0);
         if (deliv > d0 && last_pc == target) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL %s: pc %h not delivered within %0d cycles (last %h)", name, target, budget, last_pc);
      end
   endtask

   task automatic assert_reset();
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.id_ready       = 1'b0;
      pend.delete();
      last_due = 0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb_restart(RESET_PC);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0, r;
      gnt_mode = 1; rdy_mode = 1; lat_lo = 1; lat_hi = 1;
      assert_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_imem_req", bus.imem_req, 32'd0);
      check("rst_imem_addr", bus.imem_addr, RESET_PC);
      check("rst_id_valid", bus.id_valid, 32'd0);
      check("rst_id_instr", bus.id_instr, 32'd0);
      check("rst_id_pc", bus.id_pc, 32'd0);
      release_reset();

      // Sustained streaming, memory latency 1
      step(1'b0, '0);
      check("first_req", s_req, 32'd1);
      check("first_addr", s_addr, RESET_PC);
      check("fill_c0_idv", s_idv, 32'd0);
      step(1'b0, '0);
      check("fill_c1_idv", s_idv, 32'd0);
      step(1'b0, '0);
      check("fill_c2_idv", s_idv, 32'd1);
      check("fill_c2_pc", s_pc, RESET_PC);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, '0);
         if (s_idv) n++;
      end
      check("throughput", n, 32'd20);

      // Decode stall: buffer fills to DEPTH and requests stop
      assert_reset();
      release_reset();
      rdy_mode = 0;
      run(10);
      check("stall_req_low", s_req, 32'd0);
      check("stall_idv", s_idv, 32'd1);
      gnt_mode = 0; rdy_mode = 1;
      d0 = deliv;
      run(8);
      check("stall_buffered", deliv - d0, DEPTH);
      gnt_mode = 1;
      wait_pc(RESET_PC + 32'h10, 20, "stall_resume");

      // Redirect with latency 3 and responses in flight
      lat_lo = 3; lat_hi = 3;
      run(8);
      step(1'b1, 32'h100);
      step(1'b0, '0);
      check("redir_idv_off", s_idv, 32'd0);
      check("redir_addr", s_addr, 32'h100);
      wait_pc(32'h104, 30, "redir_100");

      // Misaligned redirect coincident with rvalid and a pop
      lat_lo = 1; lat_hi = 1;
      run(6);
      step(1'b1, 32'h203);
      step(1'b0, '0);
      check("redir203_idv_off", s_idv, 32'd0);
      check("redir203_addr", s_addr, 32'h200);
      wait_pc(32'h204, 20, "redir_203");

      // Back-to-back redirects while stale responses are pending
      lat_lo = 3; lat_hi = 3;
      run(6);
      step(1'b1, 32'h40);
      step(1'b1, 32'h80);
      step(1'b0, '0);
      check("b2b_idv_off", s_idv, 32'd0);
      wait_pc(32'h84, 30, "redir_b2b");

      // PC wrap-around
      lat_lo = 1; lat_hi = 2;
      step(1'b1, 32'hFFFF_FFF8);
      wait_pc(32'h0000_0004, 30, "pc_wrap");

      // Reset mid-stream with three entries buffered
      assert_reset();
      release_reset();
      gnt_mode = 1; rdy_mode = 0; lat_lo = 1; lat_hi = 1;
      run(3);
      gnt_mode = 0;
      run(2);
      check("pre_reset_idv", s_idv, 32'd1);
      assert_reset();
      #1;
      check("mid_reset_idv", bus.id_valid, 32'd0);
      check("mid_reset_req", bus.imem_req, 32'd0);
      release_reset();
      gnt_mode = 1; rdy_mode = 1;
      step(1'b0, '0);
      check("restart_req", s_req, 32'd1);
      check("restart_addr", s_addr, RESET_PC);
      wait_pc(RESET_PC + 32'h4, 10, "restart_stream");

      // Randomized traffic with occasional redirects
      gnt_mode = 2; rdy_mode = 2; lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 29));
         if (r == 0)      step(1'b1, $urandom());
         else if (r == 1) step(1'b1, 32'hFFFF_FFF0 | $urandom_range(0, 15));
         else             step(1'b0, '0);
      end
      gnt_mode = 1; rdy_mode = 1; lat_lo = 1; lat_hi = 1;
      d0 = deliv;
      run(40);
      check("drain_progress", (deliv - d0 >= 30) ? 32'd1 : 32'd0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
